// File: rtl/intersection_pkg.sv
// Shared types for the intersection controller: phase enum, lamp vector, timer sizing.
package intersection_pkg;

  typedef enum logic [2:0] {
    NS_GREEN  = 3'd0,
    NS_YELLOW = 3'd1,
    ALL_RED_A = 3'd2,
    EW_GREEN  = 3'd3,
    EW_YELLOW = 3'd4,
    ALL_RED_B = 3'd5,
    WALK      = 3'd6
  } phase_t;

  typedef struct packed {
    logic red;
    logic yellow;
    logic green;
  } lamp_t;

  localparam lamp_t LAMP_RED    = 3'b100;
  localparam lamp_t LAMP_YELLOW = 3'b010;
  localparam lamp_t LAMP_GREEN  = 3'b001;

  // One extra bit above the largest duration so every duration-1 fits unsigned.
  function automatic int timer_width(input int a, input int b, input int c, input int d);
    int m;
    m = a;
    if (b > m) m = b;
    if (c > m) m = c;
    if (d > m) m = d;
    return $clog2(m) + 1;
  endfunction

endpackage

// File: rtl/phase_timer.sv
// Loadable down-counter for phase durations; holds at zero once expired.
module phase_timer #(
  parameter int W = 4
) (
  input  logic         clk,
  input  logic         load_i,
  input  logic [W-1:0] value_i,
  output logic         expired_o
);

  logic [W-1:0] cnt_q, cnt_d;

  always_comb begin
    cnt_d = cnt_q;
    if (load_i) begin
      cnt_d = value_i;
    end else if (cnt_q != '0) begin
      cnt_d = cnt_q - W'(1);
    end
  end

  always_ff @(posedge clk) begin
    cnt_q <= cnt_d;
  end

  assign expired_o = (cnt_q == '0);

endmodule

// File: rtl/intersection_controller.sv
// Two-road intersection sequencer; NS rests on green. Define PED_WALK_EN to
// include the pedestrian WALK phase and ped_req handling.
module intersection_controller
  import intersection_pkg::*;
#(
  parameter int GREEN_TIME   = 50,
  parameter int YELLOW_TIME  = 10,
  parameter int ALL_RED_TIME = 2,
  parameter int WALK_TIME    = 20
) (
  input  logic clk,
  input  logic reset,
  input  logic ew_car,
  input  logic ped_req,
  output logic ns_red,
  output logic ns_yellow,
  output logic ns_green,
  output logic ew_red,
  output logic ew_yellow,
  output logic ew_green,
  output logic ped_walk
);

  localparam int TW = timer_width(GREEN_TIME, YELLOW_TIME, ALL_RED_TIME, WALK_TIME);

  localparam logic [TW-1:0] GREEN_LD   = TW'(GREEN_TIME - 1);
  localparam logic [TW-1:0] YELLOW_LD  = TW'(YELLOW_TIME - 1);
  localparam logic [TW-1:0] ALL_RED_LD = TW'(ALL_RED_TIME - 1);
  localparam logic [TW-1:0] WALK_LD    = TW'(WALK_TIME - 1);

  phase_t          state_q, state_d;
  logic            car_pend_q, car_pend_d;
  logic            car_eff, ped_eff;
  logic            tmr_load, tmr_expired;
  logic [TW-1:0]   tmr_value;
  lamp_t           ns_lamp, ew_lamp;

  function automatic logic [TW-1:0] phase_ld(input phase_t p);
    case (p)
      NS_GREEN, EW_GREEN:   return GREEN_LD;
      NS_YELLOW, EW_YELLOW: return YELLOW_LD;
      WALK:                 return WALK_LD;
      default:              return ALL_RED_LD;
    endcase
  endfunction

`ifdef PED_WALK_EN
  logic ped_pend_q, ped_pend_d;
  logic ret_ew_q, ret_ew_d;
  logic enter_walk;

  assign ped_eff    = ped_pend_q | ped_req;
  assign enter_walk = (state_d == WALK) && (state_q != WALK);
`else
  logic unused_ped_req;
  assign unused_ped_req = ped_req;
  assign ped_eff        = 1'b0;
`endif

  assign car_eff = car_pend_q | ew_car;

  always_comb begin
    state_d = state_q;
    case (state_q)
      NS_GREEN:  if (tmr_expired && (car_eff || ped_eff)) state_d = NS_YELLOW;
      NS_YELLOW: if (tmr_expired) state_d = ALL_RED_A;
      ALL_RED_A: if (tmr_expired) state_d = ped_eff ? WALK : EW_GREEN;
      EW_GREEN:  if (tmr_expired) state_d = EW_YELLOW;
      EW_YELLOW: if (tmr_expired) state_d = ALL_RED_B;
      ALL_RED_B: if (tmr_expired) state_d = ped_eff ? WALK : NS_GREEN;
`ifdef PED_WALK_EN
      WALK:      if (tmr_expired) state_d = ret_ew_q ? EW_GREEN : NS_GREEN;
`endif
      default:   state_d = ALL_RED_B;
    endcase
  end

  // Every phase change reloads the timer; reset loads the all-red clearance.
  assign tmr_load  = reset | (state_d != state_q);
  assign tmr_value = reset ? ALL_RED_LD : phase_ld(state_d);

  phase_timer #(.W(TW)) u_timer (
    .clk       (clk),
    .load_i    (tmr_load),
    .value_i   (tmr_value),
    .expired_o (tmr_expired)
  );

  // Set has priority over the entry clear so a request on that edge is kept.
  always_comb begin
    car_pend_d = ew_car | (car_pend_q & ~((state_d == EW_GREEN) && (state_q != EW_GREEN)));
`ifdef PED_WALK_EN
    ped_pend_d = ped_req | (ped_pend_q & ~enter_walk);
    ret_ew_d   = enter_walk ? (state_q == ALL_RED_A) : ret_ew_q;
`endif
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      state_q    <= ALL_RED_B;
      car_pend_q <= 1'b0;
`ifdef PED_WALK_EN
      ped_pend_q <= 1'b0;
      ret_ew_q   <= 1'b0;
`endif
    end else begin
      state_q    <= state_d;
      car_pend_q <= car_pend_d;
`ifdef PED_WALK_EN
      ped_pend_q <= ped_pend_d;
      ret_ew_q   <= ret_ew_d;
`endif
    end
  end

  always_comb begin
    ns_lamp = LAMP_RED;
    ew_lamp = LAMP_RED;
    case (state_q)
      NS_GREEN:  ns_lamp = LAMP_GREEN;
      NS_YELLOW: ns_lamp = LAMP_YELLOW;
      EW_GREEN:  ew_lamp = LAMP_GREEN;
      EW_YELLOW: ew_lamp = LAMP_YELLOW;
      default:   ;
    endcase
  end

  assign {ns_red, ns_yellow, ns_green} = ns_lamp;
  assign {ew_red, ew_yellow, ew_green} = ew_lamp;

`ifdef PED_WALK_EN
  assign ped_walk = (state_q == WALK);
`else
  assign ped_walk = 1'b0;
`endif

endmodule

// File: tb/tb_intersection_controller.sv
// Self-checking bench for intersection_controller: directed vector table,
// hand-written multi-cycle sequences and a randomized run against a phase-ring model.
module tb_intersection_controller;

  localparam int G  = 4;
  localparam int Y  = 2;
  localparam int AR = 1;
  localparam int W  = 3;

`ifdef PED_WALK_EN
  localparam bit PED = 1'b1;
`else
  localparam bit PED = 1'b0;
`endif

  // {ns r,y,g, ew r,y,g, walk}
  localparam logic [6:0] C_NG = 7'b001_100_0;
  localparam logic [6:0] C_NY = 7'b010_100_0;
  localparam logic [6:0] C_RR = 7'b100_100_0;
  localparam logic [6:0] C_EG = 7'b100_001_0;
  localparam logic [6:0] C_EY = 7'b100_010_0;
  localparam logic [6:0] C_WK = 7'b100_100_1;

  logic clk = 1'b0;
  logic reset, ew_car, ped_req;
  logic ns_red, ns_yellow, ns_green, ew_red, ew_yellow, ew_green, ped_walk;
  logic [6:0] lamps;

  int n_cmp = 0;
  int n_err = 0;

  always #5 clk = ~clk;

  intersection_controller #(
    .GREEN_TIME(G), .YELLOW_TIME(Y), .ALL_RED_TIME(AR), .WALK_TIME(W)
  ) dut (
    .clk(clk), .reset(reset), .ew_car(ew_car), .ped_req(ped_req),
    .ns_red(ns_red), .ns_yellow(ns_yellow), .ns_green(ns_green),
    .ew_red(ew_red), .ew_yellow(ew_yellow), .ew_green(ew_green),
    .ped_walk(ped_walk)
  );

  assign lamps = {ns_red, ns_yellow, ns_green, ew_red, ew_yellow, ew_green, ped_walk};

  // Reference model: the six road phases form a ring; WALK is a detour taken from
  // either all-red slot, after which the ring simply advances one slot.
  int         m_pos, m_age;
  bit         m_walk, m_car, m_ped;
  bit         m_ce, m_pe, m_last, m_moved;
  logic [6:0] m_exp;

  function automatic int ring_dur(input int p);
    case (p)
      0, 3:    return G;
      1, 4:    return Y;
      default: return AR;
    endcase
  endfunction

  function automatic logic [6:0] ring_code(input int p);
    case (p)
      0:       return C_NG;
      1:       return C_NY;
      3:       return C_EG;
      4:       return C_EY;
      default: return C_RR;
    endcase
  endfunction

  always @(posedge clk) begin
    if (reset) begin
      m_pos = 5; m_walk = 0; m_age = 0; m_car = 0; m_ped = 0;
    end else begin
      m_ce    = m_car | ew_car;
      m_pe    = PED && (m_ped | ped_req);
      m_last  = m_walk ? (m_age >= W - 1) : (m_age >= ring_dur(m_pos) - 1);
      m_moved = 0;
      if (m_last) begin
        if (m_walk) begin
          m_walk = 0; m_pos = (m_pos + 1) % 6; m_moved = 1;
        end else if (m_pos == 0) begin
          if (m_ce || m_pe) begin m_pos = 1; m_moved = 1; end
        end else if ((m_pos == 2 || m_pos == 5) && m_pe) begin
          m_walk = 1; m_moved = 1;
        end else begin
          m_pos = (m_pos + 1) % 6; m_moved = 1;
        end
      end
      m_age = m_moved ? 0 : m_age + 1;
      m_car = ew_car | (m_car & !(m_moved && !m_walk && m_pos == 3));
      m_ped = (PED && ped_req) | (m_ped & !(m_moved && m_walk));
    end
    m_exp = m_walk ? C_WK : ring_code(m_pos);
  end

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_cmp++;
    if (act !== exp) begin
      n_err++;
      $display("FAIL %s: got %b expected %b (t=%0t)", name, act[6:0], exp[6:0], $time);
    end
  endtask

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  typedef struct {
    logic       rst;
    logic       car;
    logic       ped;
    logic [6:0] exp;
  } vec_t;

  vec_t       tbl[$];
  logic [6:0] seq_q[$];

  task automatic addv(input logic r, input logic c, input logic p, input logic [6:0] e, input int n);
    vec_t v;
    v.rst = r; v.car = c; v.ped = p; v.exp = e;
    for (int i = 0; i < n; i++) tbl.push_back(v);
  endtask

  task automatic adds(input logic [6:0] e, input int n);
    for (int i = 0; i < n; i++) seq_q.push_back(e);
  endtask

  task automatic run_seq(input string name);
    for (int i = 0; i < seq_q.size(); i++) begin
      step();
      check($sformatf("%s[%0d]", name, i), lamps, seq_q[i]);
    end
    seq_q.delete();
  endtask

  task automatic wait_ew_green(input string name);
    int k;
    k = 0;
    while (lamps !== C_EG && k < 20) begin
      step();
      k++;
    end
    check(name, lamps, C_EG);
  endtask

  initial begin
    #1_000_000;
    $display("FAIL watchdog: simulation did not finish in time");
    $fatal(1);
  end

  initial begin
    reset = 1'b1; ew_car = 1'b0; ped_req = 1'b0;

    // Reset, release, idle NS green, then a car pulse well after expiry.
    addv(1, 0, 0, C_RR, 2);
    addv(0, 0, 0, C_NG, 10);
    addv(0, 1, 0, C_NY, 1);
    addv(0, 0, 0, C_NY, 1);
    addv(0, 0, 0, C_RR, 1);
    addv(0, 0, 0, C_EG, 4);
    addv(0, 0, 0, C_EY, 2);
    addv(0, 0, 0, C_RR, 1);
    addv(0, 0, 0, C_NG, 2);
    for (int i = 0; i < tbl.size(); i++) begin
      reset = tbl[i].rst; ew_car = tbl[i].car; ped_req = tbl[i].ped;
      step();
      check($sformatf("vec%0d", i), lamps, tbl[i].exp);
    end
    ew_car = 1'b0;

    // Car arriving before NS green expires is latched; green still lasts its minimum.
    ew_car = 1'b1;
    step();
    ew_car = 1'b0;
    check("early_pulse", lamps, C_NG);
    adds(C_NG, 1); adds(C_NY, 2); adds(C_RR, 1); adds(C_EG, 4); adds(C_EY, 2);
    adds(C_RR, 1); adds(C_NG, 1);
    run_seq("early");

    for (int i = 0; i < 100; i++) begin
      step();
      check("idle_ns_green", lamps, C_NG);
    end

    // Reset during EW green discards a pending car request.
    ew_car = 1'b1;
    step();
    ew_car = 1'b0;
    wait_ew_green("reach_ew_green_a");
    ew_car = 1'b1;
    step();
    ew_car = 1'b0;
    check("ew_green_before_reset", lamps, C_EG);
    reset = 1'b1;
    step();
    check("reset_mid_ew", lamps, C_RR);
    reset = 1'b0;
    step();
    check("after_reset_release", lamps, C_NG);
    for (int i = 0; i < 10; i++) begin
      step();
      check("latch_cleared_by_reset", lamps, C_NG);
    end

`ifdef PED_WALK_EN
    // Ped request during EW green walks after EW yellow, then returns to NS.
    ew_car = 1'b1;
    step();
    ew_car = 1'b0;
    wait_ew_green("reach_ew_green_b");
    ped_req = 1'b1;
    step();
    ped_req = 1'b0;
    check("ped_in_ew_green", lamps, C_EG);
    adds(C_EG, 2); adds(C_EY, 2); adds(C_RR, 1); adds(C_WK, 3); adds(C_NG, 1);
    run_seq("ped_after_ew");
    for (int i = 0; i < 3; i++) begin
      step();
      check("ns_green_min", lamps, C_NG);
    end

    // Simultaneous car and ped: walk first, then EW green; ped not served twice.
    ew_car = 1'b1; ped_req = 1'b1;
    step();
    ew_car = 1'b0; ped_req = 1'b0;
    check("both_req", lamps, C_NY);
    adds(C_NY, 1); adds(C_RR, 1); adds(C_WK, 3); adds(C_EG, 4); adds(C_EY, 2);
    adds(C_RR, 1); adds(C_NG, 1);
    run_seq("car_and_ped");
`else
    // Without the walk feature a ped request alone never leaves NS green.
    ped_req = 1'b1;
    step();
    ped_req = 1'b0;
    for (int i = 0; i < 20; i++) begin
      step();
      check("ped_ignored", lamps, C_NG);
    end
`endif

    // Randomized run against the model.
    reset = 1'b1;
    step();
    step();
    reset = 1'b0;
    for (int i = 0; i < 3000; i++) begin
      ew_car  = ($urandom_range(0, 15) == 0) || (ew_car && $urandom_range(0, 3) != 0);
      ped_req = ($urandom_range(0, 19) == 0);
      reset   = ($urandom_range(0, 299) == 0);
      step();
      check("rand", lamps, m_exp);
    end

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end

endmodule

// File: doc/intersection_controller.md
# intersection_controller

Sequencer for a two-road intersection. It drives two `traffic_light`-style red/yellow/green lamp sets, one for the north-south road (NS) and one for the east-west road (EW), from a single phase state machine. NS is the main road and rests on green. EW vehicle detection or a pedestrian request forces a full cycle through yellow, all-red, the optional walk phase and EW green. The block sits directly above the lamp drivers and is the only source of lamp outputs.

## Interface
- `GREEN_TIME`, default 50: minimum NS green and exact EW green, in cycles (≥1).
- `YELLOW_TIME`, default 10: yellow duration in cycles (≥1).
- `ALL_RED_TIME`, default 2: all-red clearance in cycles (≥1).
- `WALK_TIME`, default 20: pedestrian walk duration in cycles (≥1).
- `clk` in 1: sole clock, rising edge.
- `reset` in 1: synchronous, active-high.
- `ew_car` in 1: EW vehicle sensor, level or single-cycle pulse.
- `ped_req` in 1: pedestrian button, single-cycle pulse or level.
- `ns_red`, `ns_yellow`, `ns_green` out 1: NS lamps.
- `ew_red`, `ew_yellow`, `ew_green` out 1: EW lamps.
- `ped_walk` out 1: walk indicator.

## Operation
- States are NS_GREEN, NS_YELLOW, ALL_RED_A, EW_GREEN, EW_YELLOW, ALL_RED_B and WALK.
- Outputs are a Moore decode of the state register:
  - Exactly one lamp per road is lit in every state.
  - Both reds are lit in ALL_RED_A, ALL_RED_B and WALK.
  - `ped_walk` is 1 only in WALK.
- Phase timer:
  - Down-counter, loaded with duration−1 on every state entry.
  - "Expired" means timer == 0.
- Request latches:
  - `car_pend` is set by `ew_car` and cleared on entry to EW_GREEN.
  - `ped_pend` is set by `ped_req` and cleared on entry to WALK.
  - If set and clear occur in the same cycle, set wins and the request is retained.
  - Effective pending is latch OR raw input in the current cycle.
- Transitions, all taken on expiry:
  - NS_GREEN → NS_YELLOW only if car or ped is pending; otherwise stay (timer holds at 0).
  - NS_YELLOW → ALL_RED_A.
  - ALL_RED_A → WALK if ped is pending, else EW_GREEN.
  - EW_GREEN → EW_YELLOW unconditionally.
  - EW_YELLOW → ALL_RED_B.
  - ALL_RED_B → WALK if ped is pending, else NS_GREEN.
  - WALK → the green that its entering all-red state would have taken. A 1-bit `ret_ew` register, captured on WALK entry, records this.
- Timer width is `$clog2(max duration)+1`; all durations are compared unsigned.

## Timing
- Reset:
  - State ALL_RED_B with timer = ALL_RED_TIME−1.
  - Latches and `ret_ew` = 0.
  - Outputs: `ns_red` = `ew_red` = 1, all others 0.
  - Held for as long as `reset` is high.
  - Reset mid-operation aborts the current phase at the next edge; no yellow is emitted.
- Each state lasts exactly its duration in cycles, except NS_GREEN extension.
- Request latency:
  - A request sampled at an edge where NS_GREEN has expired gives NS_YELLOW in the next cycle.
  - A request arriving before expiry is latched and honoured at expiry.
- A simultaneous car and ped request in NS_GREEN produces the order yellow, all-red, WALK, EW_GREEN.
- `ped_req` asserted during WALK is retained and served at the next all-red.

## Configuration
- `PED_WALK_EN` defined:
  - WALK state, `ped_pend` and `ret_ew` are present.
  - `ped_req` can force the NS_GREEN exit.
- Not defined:
  - `ped_req` is ignored and `ped_walk` is tied to 0.
  - WALK is unreachable and removed; all-red states go directly to the next green.
  - Port list is unchanged.

## Structure
- `intersection_pkg` holds:
  - `phase_t` enum of the seven states.
  - Lamp-vector typedef `{red, yellow, green}`.
  - Timer-width constant function.
- Sub-module `phase_timer`: loadable down-counter with `load`, `value` and `expired`; parameterised width.

## Test plan
All scenarios use GREEN_TIME=4, YELLOW_TIME=2, ALL_RED_TIME=1, WALK_TIME=3 and a 10 ns clock.

1. Reset high for 2 cycles, then release → 1 cycle with `ns_red` = `ew_red` = 1, then `ns_green` = 1.
2. No requests for 100 cycles → `ns_green` stays 1 throughout and no EW lamp other than red is ever lit.
3. `ew_car` pulse 10 cycles into NS_GREEN → lamp sequence:
   - `ns_yellow` ×2
   - all-red ×1
   - `ew_green` ×4
   - `ew_yellow` ×2
   - all-red ×1
   - `ns_green`
4. `ped_req` pulse during EW_GREEN → after EW_YELLOW:
   - all-red ×1
   - `ped_walk` ×3 with both reds lit
   - `ns_green`
5. `ew_car` and `ped_req` together during NS_GREEN → NS yellow, all-red, WALK ×3, then `ew_green`; `ped_pend` = 0 afterwards.
6. Reset asserted during EW_GREEN → next cycle both reds lit and both latches 0; `ns_green` follows 1 cycle after release.
   - Repeat with `PED_WALK_EN` undefined: `ped_walk` never asserts and `ped_req` alone never leaves NS_GREEN.
